ex_branch_resolve: RTL and testbench

- Consumes the EX-stage ALU result and flags (zero, neg, carry, overflow) and resolves branches and jumps for the pipelined RV32I core.
- The front end always predicts not-taken. This block registers the resolved outcome and drives a registered redirect to fetch using a valid/ready handshake.
- It squashes wrong-path front-end stages for a fixed number of cycles and returns the link value (pc+4) for JAL/JALR.

---
 rtl/branch_pkg.sv | 28 ++
 rtl/branch_cond.sv | 29 ++
 rtl/ex_branch_resolve.sv | 187 ++++++++++++++++++
 tb/tb_ex_branch_resolve.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants and types for EX-stage branch resolution.
// The optional BRANCH_STATS_EN macro is consumed by ex_branch_resolve, not here.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [4:0] ALU_OP_ADD = 5'b00010;
  localparam logic [4:0] ALU_OP_SUB = 5'b00110;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    SQUASH
  } state_e;

  // ALU op the EX stage must issue for a control op whose flags/result we consume.
  function automatic logic [4:0] alu_op_for(input logic is_jalr);
    return is_jalr ? ALU_OP_ADD : ALU_OP_SUB;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from the flags of an rs1 - rs2 subtraction.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       neg_i,
  input  logic       carry_i,
  input  logic       overflow_i,
  output logic       taken_o,
  output logic       illegal_o
);

  // Carry is the inverted borrow: 1 means rs1 >= rs2 unsigned.
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      BEQ:     taken_o = zero_i;
      BNE:     taken_o = ~zero_i;
      BLT:     taken_o = neg_i ^ overflow_i;
      BGE:     taken_o = ~(neg_i ^ overflow_i);
      BLTU:    taken_o = ~carry_i;
      BGEU:    taken_o = carry_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_branch_resolve.sv
// Resolves EX-stage branches/jumps, issues a registered redirect and front-end squash.
// Define BRANCH_STATS_EN to add saturating branch/redirect statistics counters.
module ex_branch_resolve
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic            alu_carry,
  input  logic            alu_overflow,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush_front,
  output logic            link_valid,
  output logic [XLEN-1:0] link_data,
  output logic            misalign_err,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
`endif
  output logic            illegal_br
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rv_q, rv_d;
  logic [XLEN-1:0]   rpc_q, rpc_d;
  logic              flush_q, flush_d;
  logic              lv_q, lv_d;
  logic [XLEN-1:0]   ld_q, ld_d;
  logic              mis_q, mis_d;
  logic              ill_q, ill_d;

  logic              sel_br_c, sel_jal_c, sel_jalr_c;
  logic              cond_taken_c, cond_illegal_c;
  logic              taken_c, issue_c, eval_br_c;
  logic [XLEN-1:0]   tgt_raw_c, target_c;

  // Only a single, unambiguous control-op flag counts as a control op.
  always_comb begin
    sel_br_c   = 1'b0;
    sel_jal_c  = 1'b0;
    sel_jalr_c = 1'b0;
    if (ex_valid) begin
      case ({ex_is_branch, ex_is_jal, ex_is_jalr})
        3'b100:  sel_br_c   = 1'b1;
        3'b010:  sel_jal_c  = 1'b1;
        3'b001:  sel_jalr_c = 1'b1;
        default: ;
      endcase
    end
  end

  branch_cond u_cond (
    .funct3_i   (ex_funct3),
    .zero_i     (alu_zero),
    .neg_i      (alu_neg),
    .carry_i    (alu_carry),
    .overflow_i (alu_overflow),
    .taken_o    (cond_taken_c),
    .illegal_o  (cond_illegal_c)
  );

  assign tgt_raw_c = sel_jalr_c ? alu_result : (ex_pc + ex_imm);
  assign target_c  = tgt_raw_c & ~XLEN'(1);
  assign taken_c   = (sel_br_c & cond_taken_c) | sel_jal_c | sel_jalr_c;
  assign eval_br_c = (state_q == IDLE) & sel_br_c;
  assign issue_c   = (state_q == IDLE) & taken_c & ~target_c[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      flush_q <= 1'b0;
      lv_q    <= 1'b0;
      ld_q    <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      flush_q <= flush_d;
      lv_q    <= lv_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    flush_d = flush_q;
    lv_d    = 1'b0;
    ld_d    = ld_q;
    mis_d   = 1'b0;
    ill_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ill_d = sel_br_c & cond_illegal_c;
        if (sel_jal_c || sel_jalr_c) begin
          lv_d = 1'b1;
          ld_d = ex_pc + XLEN'(4);
        end
        if (taken_c) begin
          if (target_c[1]) begin
            mis_d = 1'b1;
          end else begin
            rv_d    = 1'b1;
            rpc_d   = target_c;
            flush_d = 1'b1;
            state_d = REDIRECT;
          end
        end
      end
      REDIRECT: begin
        if (rv_q && redirect_ready) begin
          rv_d    = 1'b0;
          cnt_d   = CNT_W'(FLUSH_DEPTH - 1);
          state_d = SQUASH;
        end
      end
      SQUASH: begin
        if (cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        rv_d    = 1'b0;
        flush_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign flush_front    = flush_q;
  assign link_valid     = lv_q;
  assign link_data      = ld_q;
  assign misalign_err   = mis_q;
  assign illegal_br     = ill_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_tk_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_tk_q <= '0;
    end else begin
      if (eval_br_c && (stat_br_q != '1)) stat_br_q <= stat_br_q + 32'd1;
      if (issue_c && (stat_tk_q != '1))   stat_tk_q <= stat_tk_q + 32'd1;
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_taken    = stat_tk_q;
`else
  logic unused_c;
  assign unused_c = eval_br_c ^ issue_c;
`endif

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed self-checking bench for ex_branch_resolve (FLUSH_DEPTH = 2).
module tb_ex_branch_resolve;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FD   = 2;

  logic            clk;
  logic            rst_n;
  logic            ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc, ex_imm, alu_result;
  logic            alu_zero, alu_neg, alu_carry, alu_overflow;
  logic            redirect_valid, redirect_ready, flush_front;
  logic [XLEN-1:0] redirect_pc, link_data;
  logic            link_valid, misalign_err, illegal_br;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_branches, stat_taken;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int nflush;

  ex_branch_resolve #(.XLEN(XLEN), .FLUSH_DEPTH(FD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .alu_neg        (alu_neg),
    .alu_carry      (alu_carry),
    .alu_overflow   (alu_overflow),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush_front    (flush_front),
    .link_valid     (link_valid),
    .link_data      (link_data),
    .misalign_err   (misalign_err),
`ifdef BRANCH_STATS_EN
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken),
`endif
    .illegal_br     (illegal_br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 3'b000; ex_pc = '0; ex_imm = '0; alu_result = '0;
    alu_zero = 0; alu_neg = 0; alu_carry = 0; alu_overflow = 0;
  endtask

  // Flags of a 32-bit rs1 - rs2; carry is the inverted borrow.
  task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm);
    logic [31:0] d;
    d = a - b;
    ex_valid = 1; ex_is_branch = 1; ex_funct3 = f3; ex_pc = pc; ex_imm = imm;
    alu_result   = d;
    alu_zero     = (d == 32'd0);
    alu_neg      = d[31];
    alu_carry    = (a >= b);
    alu_overflow = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue();
    step();
    clear_ex();
  endtask

  task automatic count_flush(output int n);
    n = 0;
    while (flush_front === 1'b1 && n < 20) begin
      n++;
      step();
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && (redirect_valid !== 1'b0 || flush_front !== 1'b0); i++) step();
    check("idle_reached", {30'd0, redirect_valid, flush_front}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rv"},    {31'd0, redirect_valid}, 32'd0);
    check({tag, "_rpc"},   redirect_pc, 32'd0);
    check({tag, "_flush"}, {31'd0, flush_front}, 32'd0);
    check({tag, "_misc"},  {29'd0, link_valid, misalign_err, illegal_br}, 32'd0);
    check({tag, "_ld"},    link_data, 32'd0);
  endtask

  initial begin
    rst_n = 0;
    redirect_ready = 1;
    clear_ex();
    step(); step();
    check_all_zero("reset");
    #2 rst_n = 1;
    step();

    // BEQ 5==5, pc 0x100 + 0x20, then measure the full flush window
    set_br(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
    issue();
    check("beq_rv",    {31'd0, redirect_valid}, 32'd1);
    check("beq_pc",    redirect_pc, 32'h120);
    check("beq_flush", {31'd0, flush_front}, 32'd1);
    count_flush(nflush);
    check("beq_flush_len", nflush, FD + 1);
    check("beq_rv_after", {31'd0, redirect_valid}, 32'd0);

    // BLTU 1<2 taken, negative offset
    set_br(3'b110, 32'd1, 32'd2, 32'h200, 32'hFFFF_FFF8);
    issue();
    check("bltu_rv", {31'd0, redirect_valid}, 32'd1);
    check("bltu_pc", redirect_pc, 32'h1F8);
    wait_idle();

    // BGEU 1>=2 not taken
    set_br(3'b111, 32'd1, 32'd2, 32'h200, 32'h40);
    issue();
    check("bgeu_nt", {30'd0, redirect_valid, flush_front}, 32'd0);

    // BLT -1<1 taken
    set_br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10);
    issue();
    check("blt_rv", {31'd0, redirect_valid}, 32'd1);
    check("blt_pc", redirect_pc, 32'h310);
    wait_idle();

    // BNE 5!=5 not taken
    set_br(3'b001, 32'd5, 32'd5, 32'h300, 32'h10);
    issue();
    check("bne_nt", {30'd0, redirect_valid, flush_front}, 32'd0);

    // JALR aligned: bit 0 cleared, link written
    ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h40; alu_result = 32'h205;
    issue();
    check("jalr_rv", {31'd0, redirect_valid}, 32'd1);
    check("jalr_pc", redirect_pc, 32'h204);
    check("jalr_lv", {31'd0, link_valid}, 32'd1);
    check("jalr_ld", link_data, 32'h44);
    step();
    check("jalr_lv_pulse", {31'd0, link_valid}, 32'd0);
    wait_idle();

    // JALR misaligned: error pulse, link still written, no redirect
    ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h40; alu_result = 32'h206;
    issue();
    check("jalrm_mis", {31'd0, misalign_err}, 32'd1);
    check("jalrm_rv",  {30'd0, redirect_valid, flush_front}, 32'd0);
    check("jalrm_lv",  {31'd0, link_valid}, 32'd1);
    check("jalrm_ld",  link_data, 32'h44);
    step();
    check("jalrm_mis_pulse", {31'd0, misalign_err}, 32'd0);

    // Taken branch with target bit 1 set
    set_br(3'b000, 32'd3, 32'd3, 32'h100, 32'h2);
    issue();
    check("brm_mis", {31'd0, misalign_err}, 32'd1);
    check("brm_rv",  {31'd0, redirect_valid}, 32'd0);

    // JAL wrapping past 2^32
    ex_valid = 1; ex_is_jal = 1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h20;
    issue();
    check("jal_pc", redirect_pc, 32'h10);
    check("jal_ld", link_data, 32'hFFFF_FFF4);
    wait_idle();

    // Two control flags at once: treated as non-control
    set_br(3'b000, 32'd7, 32'd7, 32'h500, 32'h8);
    ex_is_jal = 1;
    issue();
    check("multi_sel", {29'd0, redirect_valid, link_valid, flush_front}, 32'd0);

    // Backpressure: later taken branches in REDIRECT are ignored
    redirect_ready = 0;
    set_br(3'b000, 32'd1, 32'd1, 32'h400, 32'h40);
    issue();
    for (int i = 0; i < 3; i++) begin
      if (i != 1) set_br(3'b000, 32'd2, 32'd2, 32'h800, 32'h100);
      issue();
      check("bp_rv", {30'd0, redirect_valid, flush_front}, 32'd3);
      check("bp_pc", redirect_pc, 32'h440);
    end
    redirect_ready = 1;
    step();
    check("bp_acc_rv", {31'd0, redirect_valid}, 32'd0);
    count_flush(nflush);
    check("bp_flush_len", nflush, FD);
    check("bp_no_extra", {31'd0, redirect_valid}, 32'd0);

    // Asynchronous reset mid-redirect
    redirect_ready = 0;
    set_br(3'b000, 32'd9, 32'd9, 32'h600, 32'h20);
    issue();
    check("rst_pre_rv", {31'd0, redirect_valid}, 32'd1);
    #2 rst_n = 0;
    #1 check_all_zero("rst_mid");
    step();
    #2 rst_n = 1;
    redirect_ready = 1;
    step(); step();
    check("rst_post", {30'd0, redirect_valid, flush_front}, 32'd0);

    // Illegal funct3
    set_br(3'b010, 32'd4, 32'd4, 32'h700, 32'h10);
    issue();
    check("ill_pulse", {31'd0, illegal_br}, 32'd1);
    check("ill_rv",    {31'd0, redirect_valid}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("stat_br_ill", stat_branches, 32'd1);
    check("stat_tk_ill", stat_taken, 32'd0);
`endif
    step();
    check("ill_pulse_end", {31'd0, illegal_br}, 32'd0);

`ifdef BRANCH_STATS_EN
    set_br(3'b000, 32'd1, 32'd1, 32'h100, 32'h10);
    issue();
    check("stat_br_tk", stat_branches, 32'd2);
    check("stat_tk_tk", stat_taken, 32'd1);
    wait_idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
